// File: rtl/gray_counter_if.sv
// Control and result bundle for gray_counter.
// The counter takes the slave side; whoever drives the controls takes the master side.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             i_en;
  logic             i_dir;
  logic             i_clr;
  logic             i_load;
  logic [WIDTH-1:0] i_loadValue;
  logic [WIDTH-1:0] o_greyCode;
  logic [WIDTH-1:0] o_bin;
  logic             o_tc;
  logic             o_wrap;

  modport master (
    output i_en, i_dir, i_clr, i_load, i_loadValue,
    input  o_greyCode, o_bin, o_tc, o_wrap
  );

  modport slave (
    input  i_en, i_dir, i_clr, i_load, i_loadValue,
    output o_greyCode, o_bin, o_tc, o_wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Parametrised up/down Gray counter with clear, load, and wrap or saturate mode.
// Gray and binary are registered on the same edge, so the two outputs never skew.
module gray_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  gray_counter_if.slave cnt
);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             tc;

  always_comb begin
    tc = (cnt.i_dir && (bin_reg == MAX_VAL)) || (!cnt.i_dir && (bin_reg == '0));
  end

  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (cnt.i_clr) begin
      bin_next = '0;
    end else if (cnt.i_load) begin
      bin_next = cnt.i_loadValue;
    end else if (cnt.i_en) begin
      // In saturate mode a step off the terminal value is simply dropped.
      if (!(SATURATE && tc)) begin
        bin_next  = cnt.i_dir ? (bin_reg + ONE) : (bin_reg - ONE);
        wrap_next = tc;
      end
    end
  end

  // Gray encoding of the next binary value: each bit is the XOR of adjacent binary bits.
  assign gray_next[WIDTH-1] = bin_next[WIDTH-1];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign cnt.o_bin      = bin_reg;
  assign cnt.o_greyCode = gray_reg;
  assign cnt.o_tc       = tc;
  assign cnt.o_wrap     = wrap_reg;
endmodule
